chip8_tick_scheduler: RTL
=========================

# chip8_tick_scheduler

Run-control and time-base controller for the CHIP-8 core. Derives the 540 Hz instruction clock and the 60 Hz frame tick from the system clock. Provides run/pause/single-step control for debug, and owns the delay and sound timers that drive the buzzer. Sits between the board clock domain and the `chip8` instance's `instruction_clk` input.

## Interface
- `TICK_DIV`, 1852: system-clock cycles per instruction period (1 MHz / 540); must be ≥ 4.
- `INSTR_PER_FRAME`, 9: instruction ticks per 60 Hz timer frame; must be ≥ 1.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; 1 = free-run instructions, 0 = pause.
- `step`  in  1  single-cycle pulse; issue exactly one instruction while paused.
- `dt_load`  in  1  load delay timer from `dt_value` (Fx15).
- `dt_value`  in  8  delay timer load value.
- `st_load`  in  1  load sound timer from `st_value` (Fx18).
- `st_value`  in  8  sound timer load value.
- `instr_clk`  out  1  square-ish clock for `chip8.instruction_clk`.
- `instr_tick`  out  1  one-cycle pulse per issued instruction.
- `frame_tick`  out  1  one-cycle pulse per timer frame.
- `dt`  out  8  current delay timer (Fx07).
- `st`  out  8  current sound timer.
- `buzzer`  out  1  high while `st != 0`.
- `running`  out  1  high in RUNNING state.

## Operation
- Reset: state PAUSED, divider = 0, frame counter = 0, `dt = st = 0`, all outputs 0.
- Every output is registered.
- PAUSED:
  - Divider and frame counter hold.
  - `run = 1` → RUNNING.
  - Else `step = 1` → STEPPING.
- RUNNING:
  - Divider increments each cycle, 0..TICK_DIV-1, then wraps to 0.
  - The cycle after the divider wraps: `instr_tick = 1` and `instr_clk` rises.
  - `instr_clk` stays high for TICK_DIV/2 (integer) cycles, then low for the rest of the period.
  - `run = 0` → PAUSED next cycle. `instr_clk` is forced low. Divider value is retained, so resume continues the partial period.
  - `step` is ignored.
- STEPPING:
  - First cycle: `instr_tick = 1`, `instr_clk` rises. It stays high TICK_DIV/2 cycles, then low TICK_DIV/2 cycles.
  - After that, → RUNNING if `run = 1`, else PAUSED.
  - Divider is untouched. `step` pulses during STEPPING are dropped, not queued.
- Frame counter:
  - Advances on every `instr_tick`, in both RUNNING and STEPPING.
  - Wraps at INSTR_PER_FRAME-1 → 0.
  - `frame_tick` is asserted in the same cycle as the `instr_tick` that causes the wrap.
- Timers, evaluated on the frame_tick cycle:
  - `dt` decrements if nonzero; `st` likewise. 0 saturates and never wraps to 255.
  - Load beats decrement in the same cycle: the loaded value is taken unmodified.
  - Loads are accepted in any state, including PAUSED.
  - `buzzer` follows `st != 0` combinationally from the `st` register.
  - `st_load` with 0 silences the buzzer in the next cycle.

## Timing
- After reset, first `instr_tick` is TICK_DIV cycles after the first RUNNING cycle.
- Subsequent ticks are every TICK_DIV cycles exactly; there is no drift.
- Step latency: `step` sampled at edge N → `instr_tick` at cycle N+1 → state leaves STEPPING at N+1+2·(TICK_DIV/2).
- `run` and `step` in the same cycle while PAUSED: `run` wins, and `step` is dropped.
- `rst` mid-period or mid-step: everything clears immediately (asynchronous).
  - `instr_clk` drops to 0 with no glitch pulse after release.
  - No tick in the first cycle after release.
- `running` = 1 exactly while the state is RUNNING.
- Frame rate at defaults: 540/9 = 60 Hz.

## Test plan
All scenarios use TICK_DIV=8, INSTR_PER_FRAME=3.
- Reset, then hold `run = 1` → `instr_tick` at cycles 8, 16, 24 after RUNNING entry. `instr_clk` high 4 cycles per period. `frame_tick` on every 3rd tick.
- `dt_load` 5 while running → `dt` reads 5, 4, 3, 2, 1, 0 on successive frame_ticks, then holds 0. `st_load` 2 → `buzzer` high for exactly 2 frames.
- Paused; `step` pulse ×3 spaced 20 cycles apart → exactly 3 `instr_tick`s, 1 `frame_tick`. Divider value unchanged.
- `step` pulses at 1 and 3 cycles after the first `step` → only one `instr_tick`.
- `run` dropped at divider = 5, re-asserted 10 cycles later → next `instr_tick` 3 cycles after resume. `instr_clk` low throughout the pause.
- `dt_load` 7 coincident with `frame_tick` (dt was 4) → `dt` = 7, not 6.
- `rst` asserted while `instr_clk` is high in STEPPING → all outputs 0 immediately. State PAUSED after release.

Source files
------------

// File: rtl/chip8_tick_scheduler.sv
// chip8_tick_scheduler
// Run-control and time base for the CHIP-8 core. Divides the system clock
// down to the instruction clock, generates the 60 Hz frame tick, provides
// run / pause / single-step control for debug, and owns the delay and sound
// timers that drive the buzzer. Every output comes straight from a register.
module chip8_tick_scheduler #(
  parameter int TICK_DIV        = 1852,
  parameter int INSTR_PER_FRAME = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic       dt_load,
  input  logic [7:0] dt_value,
  input  logic       st_load,
  input  logic [7:0] st_value,
  output logic       instr_clk,
  output logic       instr_tick,
  output logic       frame_tick,
  output logic [7:0] dt,
  output logic [7:0] st,
  output logic       buzzer,
  output logic       running
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FR_W  = (INSTR_PER_FRAME > 1) ? $clog2(INSTR_PER_FRAME) : 1;

  // Last divider count of a period, last count of the high phase, and last
  // count of a single step (two equal halves, so an odd TICK_DIV loses one).
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(TICK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] STEP_LAST = DIV_W'(2 * (TICK_DIV / 2) - 1);
  localparam logic [FR_W-1:0]  FR_LAST   = FR_W'(INSTR_PER_FRAME - 1);

  typedef enum logic [1:0] {
    PAUSED   = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_stepCnt;
  logic [FR_W-1:0]  r_frameCnt;
  logic             r_instrClk;
  logic             r_instrTick;
  logic             r_frameTick;
  logic             r_running;
  logic [7:0]       r_dt;
  logic [7:0]       r_st;
  logic             r_buzzer;

  logic             w_frameWrap;
  logic [FR_W-1:0]  w_frameNext;
  logic [7:0]       w_dtNext;
  logic [7:0]       w_stNext;

  // Frame counter successor, applied whenever an instruction tick is issued.
  always_comb begin
    w_frameWrap = (r_frameCnt == FR_LAST);
    w_frameNext = w_frameWrap ? '0 : (r_frameCnt + FR_W'(1));
  end

  // Timer successors: a load wins over the frame decrement, zero saturates.
  always_comb begin
    w_dtNext = r_dt;
    w_stNext = r_st;
    if (dt_load) begin
      w_dtNext = dt_value;
    end else if (r_frameTick && (r_dt != 8'd0)) begin
      w_dtNext = r_dt - 8'd1;
    end
    if (st_load) begin
      w_stNext = st_value;
    end else if (r_frameTick && (r_st != 8'd0)) begin
      w_stNext = r_st - 8'd1;
    end
  end

  // Run-control FSM with divider, step counter, frame counter and tick outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= PAUSED;
      r_div       <= '0;
      r_stepCnt   <= '0;
      r_frameCnt  <= '0;
      r_instrClk  <= 1'b0;
      r_instrTick <= 1'b0;
      r_frameTick <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_instrTick <= 1'b0;
      r_frameTick <= 1'b0;
      unique case (r_state)
        PAUSED: begin
          r_instrClk <= 1'b0;
          if (run) begin
            r_state   <= RUNNING;
            r_running <= 1'b1;
          end else if (step) begin
            r_state     <= STEPPING;
            r_stepCnt   <= '0;
            r_instrClk  <= 1'b1;
            r_instrTick <= 1'b1;
            r_frameCnt  <= w_frameNext;
            r_frameTick <= w_frameWrap;
          end
        end
        RUNNING: begin
          if (!run) begin
            r_state    <= PAUSED;
            r_running  <= 1'b0;
            r_instrClk <= 1'b0;
          end else if (r_div == DIV_LAST) begin
            r_div       <= '0;
            r_instrClk  <= 1'b1;
            r_instrTick <= 1'b1;
            r_frameCnt  <= w_frameNext;
            r_frameTick <= w_frameWrap;
          end else begin
            r_div <= r_div + DIV_W'(1);
            if (r_div == HALF_LAST) begin
              r_instrClk <= 1'b0;
            end
          end
        end
        STEPPING: begin
          if (r_stepCnt == HALF_LAST) begin
            r_instrClk <= 1'b0;
          end
          if (r_stepCnt == STEP_LAST) begin
            if (run) begin
              r_state   <= RUNNING;
              r_running <= 1'b1;
            end else begin
              r_state <= PAUSED;
            end
          end else begin
            r_stepCnt <= r_stepCnt + DIV_W'(1);
          end
        end
        default: begin
          r_state    <= PAUSED;
          r_running  <= 1'b0;
          r_instrClk <= 1'b0;
        end
      endcase
    end
  end

  // Delay and sound timers; the buzzer register tracks the next sound value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dt     <= 8'd0;
      r_st     <= 8'd0;
      r_buzzer <= 1'b0;
    end else begin
      r_dt     <= w_dtNext;
      r_st     <= w_stNext;
      r_buzzer <= (w_stNext != 8'd0);
    end
  end

  assign instr_clk  = r_instrClk;
  assign instr_tick = r_instrTick;
  assign frame_tick = r_frameTick;
  assign dt         = r_dt;
  assign st         = r_st;
  assign buzzer     = r_buzzer;
  assign running    = r_running;

endmodule
